// File: rtl/mips_defs.sv
// Shared encoding constants for the MIPS subset handled by the decoder/encoder pair.
package mips_defs;

  // Primary opcodes
  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // Function codes under OP_OTHER0
  localparam logic [5:0] OP0_JR    = 6'h08;
  localparam logic [5:0] OP0_ADD   = 6'h20;
  localparam logic [5:0] OP0_SUB   = 6'h22;
  localparam logic [5:0] OP0_AND   = 6'h24;
  localparam logic [5:0] OP0_OR    = 6'h25;
  localparam logic [5:0] OP0_XOR   = 6'h26;
  localparam logic [5:0] OP0_NOR   = 6'h27;
  localparam logic [5:0] OP0_SLT   = 6'h2a;
  localparam logic [5:0] OP0_ADDM  = 6'h2c;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J,
    FMT_BAD
  } fmt_e;

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy count; head is read from registered storage.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_not_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full blocks pushes outright, even when a pop happens in the same cycle.
  assign w_push     = i_push && (r_count != FULL);
  assign w_pop      = i_pop && (r_count != '0);
  assign o_not_full = (r_count != FULL);
  assign o_valid    = (r_count != '0);
  assign o_data     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;

  // Storage write; contents need no reset since the head is gated by count.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mips_encode.sv
// Packs instruction fields into 32-bit MIPS words, queues legal ones, flags and counts illegal ones.
module mips_encode
  import mips_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ERRW  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [15:0]           imm,
  input  logic [25:0]           target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic                  err,
  output logic [ERRW-1:0]       err_count
);

  fmt_e            w_fmt;
  logic [31:0]     w_word;
  logic            w_accept;
  logic            w_push;
  logic            w_unused;
  logic            r_err;
  logic [ERRW-1:0] r_err_count;

  // Every supported R-type forces shamt to zero, so the field never reaches the word.
  assign w_unused = ^shamt;

  // Classify the request and build its instruction word.
  always_comb begin
    w_fmt  = FMT_BAD;
    w_word = '0;
    case (opcode)
      OP_OTHER0: begin
        case (funct)
          OP0_JR: begin
            w_fmt  = FMT_R;
            w_word = {6'b0, rs, 5'b0, 5'b0, 5'b0, funct};
          end
          OP0_ADD, OP0_SUB, OP0_AND, OP0_OR, OP0_NOR,
          OP0_XOR, OP0_SLT, OP0_ADDM: begin
            w_fmt  = FMT_R;
            w_word = {6'b0, rs, rt, rd, 5'b0, funct};
          end
          default: ;
        endcase
      end
      OP_LUI: begin
        w_fmt  = FMT_I;
        w_word = {opcode, 5'b0, rt, imm};
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_BEQ, OP_BNE,
      OP_LW, OP_LBU, OP_SW, OP_SB: begin
        w_fmt  = FMT_I;
        w_word = {opcode, rs, rt, imm};
      end
      OP_J: begin
        w_fmt  = FMT_J;
        w_word = {opcode, target};
      end
      default: ;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && (w_fmt != FMT_BAD);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clock    (clock),
    .i_rst_n    (reset),
    .i_push     (w_push),
    .i_data     (w_word),
    .i_pop      (out_ready),
    .o_not_full (in_ready),
    .o_valid    (out_valid),
    .o_data     (out_instr),
    .o_count    (count)
  );

  // Error pulse for an accepted illegal request, plus saturating tally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= w_accept && (w_fmt == FMT_BAD);
      if (w_accept && (w_fmt == FMT_BAD) && (r_err_count != '1))
        r_err_count <= r_err_count + ERRW'(1);
    end
  end

  assign err       = r_err;
  assign err_count = r_err_count;

endmodule
